// File: rtl/dot_accumulator_if.sv
// Handshake bundle between the dot-product pipeline, the accumulator and the result consumer.
// The master side drives beats and out_ready; the slave side is the accumulator itself.
interface dot_accumulator_if #(
  parameter int IN_W  = 32,
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
);
  logic             clear;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_beats;
  logic             out_ovf;

  modport master (
    output clear, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_beats, out_ovf
  );

  modport slave (
    input  clear, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_beats, out_ovf
  );
endinterface

// File: rtl/dot_accumulator.sv
// Sums consecutive partial dot products into one vector result, counts beats, flags overflow,
// and holds the completed result in a one-entry valid/ready output register.
module dot_accumulator #(
  parameter int IN_W  = 32,
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  dot_accumulator_if.slave bus
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           r_state, w_state_next;
  logic [ACC_W-1:0] r_acc, w_acc_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_ovf, w_ovf_next;

  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_beats;
  logic             r_out_ovf;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_load;
  logic [ACC_W-1:0] w_in_ext;
  logic [ACC_W-1:0] w_acc_base;
  logic [CNT_W-1:0] w_cnt_base;
  logic             w_ovf_base;
  logic [ACC_W:0]   w_sum_full;
  logic             w_cnt_sat;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_ovf_inc;

  assign w_in_ready = ~r_out_valid | bus.out_ready;
  assign w_accept   = bus.in_valid & w_in_ready;

  // In IDLE the running values are treated as zero, so the first beat of a
  // vector (including a single-beat vector) goes through the same adder.
  assign w_acc_base = (r_state == ACCUM) ? r_acc : '0;
  assign w_cnt_base = (r_state == ACCUM) ? r_cnt : '0;
  assign w_ovf_base = (r_state == ACCUM) ? r_ovf : 1'b0;

  assign w_in_ext   = ACC_W'(bus.in_data);
  assign w_sum_full = {1'b0, w_acc_base} + {1'b0, w_in_ext};
  assign w_cnt_sat  = &w_cnt_base;
  assign w_cnt_inc  = w_cnt_sat ? w_cnt_base : w_cnt_base + 1'b1;
  assign w_ovf_inc  = w_ovf_base | w_sum_full[ACC_W] | w_cnt_sat;

  // NOTE: every always_comb output is given a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_ovf_next   = r_ovf;
    w_load       = 1'b0;
    if (bus.clear) begin
      w_state_next = IDLE;
      w_acc_next   = '0;
      w_cnt_next   = '0;
      w_ovf_next   = 1'b0;
    end else if (w_accept) begin
      if (bus.in_last) begin
        w_load       = 1'b1;
        w_state_next = IDLE;
        w_acc_next   = '0;
        w_cnt_next   = '0;
        w_ovf_next   = 1'b0;
      end else begin
        w_state_next = ACCUM;
        w_acc_next   = w_sum_full[ACC_W-1:0];
        w_cnt_next   = w_cnt_inc;
        w_ovf_next   = w_ovf_inc;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_ovf   <= w_ovf_next;
    end
  end

  // A load in the same cycle as a drain simply overwrites, keeping out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_beats <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_sum_full[ACC_W-1:0];
      r_out_beats <= w_cnt_inc;
      r_out_ovf   <= w_ovf_inc;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_beats = r_out_beats;
  assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed bench for dot_accumulator built with ACC_W=IN_W=32 (to reach carry-out)
// and CNT_W=3 (so beat-count saturation happens after seven beats).
module tb_dot_accumulator;

  localparam int IN_W  = 32;
  localparam int ACC_W = 32;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  dot_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  dot_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Inputs change on the falling edge; outputs are read there too, half a cycle from the active edge.
  task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic l);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    if (bus.out_valid !== 1'b0) begin $display("FAIL reset out_valid: got %0b want 0", bus.out_valid); n_errors++; end
    n_checks++;
    if (bus.out_sum !== 32'd0) begin $display("FAIL reset out_sum: got %0d want 0", bus.out_sum); n_errors++; end
    n_checks++;
    if (bus.out_beats !== 3'd0) begin $display("FAIL reset out_beats: got %0d want 0", bus.out_beats); n_errors++; end
    n_checks++;
    if (bus.out_ovf !== 1'b0) begin $display("FAIL reset out_ovf: got %0b want 0", bus.out_ovf); n_errors++; end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin $display("FAIL reset in_ready: got %0b want 1", bus.in_ready); n_errors++; end
    n_checks++;
  endtask

  task automatic test_two_beats();
    drive(1'b1, 32'd6, 1'b0); tick();
    if (bus.out_valid !== 1'b0) begin $display("FAIL two_beat early_valid: got %0b want 0", bus.out_valid); n_errors++; end
    n_checks++;
    drive(1'b1, 32'd6, 1'b1); tick();
    drive(1'b0, 32'd0, 1'b0);
    if (bus.out_valid !== 1'b1) begin $display("FAIL two_beat out_valid: got %0b want 1", bus.out_valid); n_errors++; end
    n_checks++;
    if (bus.out_sum !== 32'd12) begin $display("FAIL two_beat out_sum: got %0d want 12", bus.out_sum); n_errors++; end
    n_checks++;
    if (bus.out_beats !== 3'd2) begin $display("FAIL two_beat out_beats: got %0d want 2", bus.out_beats); n_errors++; end
    n_checks++;
    if (bus.out_ovf !== 1'b0) begin $display("FAIL two_beat out_ovf: got %0b want 0", bus.out_ovf); n_errors++; end
    n_checks++;
    tick();
    if (bus.out_valid !== 1'b0) begin $display("FAIL two_beat drain: got %0b want 0", bus.out_valid); n_errors++; end
    n_checks++;
  endtask

  task automatic test_single_beat();
    drive(1'b1, 32'd7, 1'b1); tick();
    drive(1'b0, 32'd0, 1'b0);
    if (bus.out_sum !== 32'd7 || bus.out_beats !== 3'd1 || bus.out_valid !== 1'b1) begin
      $display("FAIL single sum/beats/valid: got %0d/%0d/%0b want 7/1/1", bus.out_sum, bus.out_beats, bus.out_valid); n_errors++;
    end
    n_checks++;
    tick();
    // Still IDLE: the next single beat must not include the 7.
    drive(1'b1, 32'd2, 1'b1); tick();
    drive(1'b0, 32'd0, 1'b0);
    if (bus.out_sum !== 32'd2 || bus.out_beats !== 3'd1) begin
      $display("FAIL single idle_after: got %0d/%0d want 2/1", bus.out_sum, bus.out_beats); n_errors++;
    end
    n_checks++;
    tick();
  endtask

  task automatic test_gap();
    drive(1'b1, 32'd10, 1'b0); tick();
    drive(1'b0, 32'd55, 1'b1); tick();
    drive(1'b0, 32'd66, 1'b0); tick();
    drive(1'b1, 32'd20, 1'b1); tick();
    drive(1'b0, 32'd0, 1'b0);
    if (bus.out_sum !== 32'd30 || bus.out_beats !== 3'd2) begin
      $display("FAIL gap sum/beats: got %0d/%0d want 30/2", bus.out_sum, bus.out_beats); n_errors++;
    end
    n_checks++;
    tick();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'd1, 1'b0); tick();
    drive(1'b1, 32'd2, 1'b1); tick();
    drive(1'b1, 32'd5, 1'b1);
    #1;
    if (bus.in_ready !== 1'b0) begin $display("FAIL bp in_ready: got %0b want 0", bus.in_ready); n_errors++; end
    n_checks++;
    if (bus.out_sum !== 32'd3 || bus.out_beats !== 3'd2) begin
      $display("FAIL bp first_result: got %0d/%0d want 3/2", bus.out_sum, bus.out_beats); n_errors++;
    end
    n_checks++;
    tick(); tick();
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 32'd3) begin
      $display("FAIL bp hold: got valid=%0b sum=%0d want 1/3", bus.out_valid, bus.out_sum); n_errors++;
    end
    n_checks++;
    // Drain of 3 and load of 5 share one edge.
    bus.out_ready = 1'b1;
    #1;
    if (bus.in_ready !== 1'b1) begin $display("FAIL bp in_ready_release: got %0b want 1", bus.in_ready); n_errors++; end
    n_checks++;
    tick();
    drive(1'b0, 32'd0, 1'b0);
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 32'd5 || bus.out_beats !== 3'd1) begin
      $display("FAIL bp replace: got %0b/%0d/%0d want 1/5/1", bus.out_valid, bus.out_sum, bus.out_beats); n_errors++;
    end
    n_checks++;
    tick();
    if (bus.out_valid !== 1'b0) begin $display("FAIL bp drain: got %0b want 0", bus.out_valid); n_errors++; end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    logic [IN_W-1:0] vals [3] = '{32'd11, 32'd22, 32'd33};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], 1'b1); tick();
      if (bus.out_valid !== 1'b1 || bus.out_sum !== vals[i]) begin
        $display("FAIL b2b[%0d]: got valid=%0b sum=%0d want 1/%0d", i, bus.out_valid, bus.out_sum, vals[i]); n_errors++;
      end
      n_checks++;
    end
    drive(1'b0, 32'd0, 1'b0); tick();
  endtask

  task automatic test_overflow();
    drive(1'b1, 32'hFFFF_FFFF, 1'b0); tick();
    drive(1'b1, 32'h0000_0002, 1'b1); tick();
    drive(1'b0, 32'd0, 1'b0);
    if (bus.out_sum !== 32'd1 || bus.out_ovf !== 1'b1) begin
      $display("FAIL ovf wrap: got sum=%0d ovf=%0b want 1/1", bus.out_sum, bus.out_ovf); n_errors++;
    end
    n_checks++;
    tick();
    drive(1'b1, 32'd4, 1'b1); tick();
    drive(1'b0, 32'd0, 1'b0);
    if (bus.out_sum !== 32'd4 || bus.out_ovf !== 1'b0) begin
      $display("FAIL ovf cleared: got sum=%0d ovf=%0b want 4/0", bus.out_sum, bus.out_ovf); n_errors++;
    end
    n_checks++;
    tick();
    // Carry on a middle beat must persist to the result.
    drive(1'b1, 32'hFFFF_FFFF, 1'b0); tick();
    drive(1'b1, 32'h0000_0002, 1'b0); tick();
    drive(1'b1, 32'h0000_0003, 1'b1); tick();
    drive(1'b0, 32'd0, 1'b0);
    if (bus.out_sum !== 32'd4 || bus.out_ovf !== 1'b1 || bus.out_beats !== 3'd3) begin
      $display("FAIL ovf sticky: got %0d/%0b/%0d want 4/1/3", bus.out_sum, bus.out_ovf, bus.out_beats); n_errors++;
    end
    n_checks++;
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'd1, (i == 6)); tick();
    end
    drive(1'b0, 32'd0, 1'b0);
    if (bus.out_sum !== 32'd7 || bus.out_beats !== 3'd7 || bus.out_ovf !== 1'b0) begin
      $display("FAIL sat seven: got %0d/%0d/%0b want 7/7/0", bus.out_sum, bus.out_beats, bus.out_ovf); n_errors++;
    end
    n_checks++;
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'd1, (i == 7)); tick();
    end
    drive(1'b0, 32'd0, 1'b0);
    if (bus.out_sum !== 32'd8 || bus.out_beats !== 3'd7 || bus.out_ovf !== 1'b1) begin
      $display("FAIL sat eight: got %0d/%0d/%0b want 8/7/1", bus.out_sum, bus.out_beats, bus.out_ovf); n_errors++;
    end
    n_checks++;
    tick();
  endtask

  task automatic test_clear();
    drive(1'b1, 32'd10, 1'b0); tick();
    drive(1'b1, 32'd20, 1'b0); tick();
    drive(1'b1, 32'd99, 1'b1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    drive(1'b0, 32'd0, 1'b0);
    if (bus.out_valid !== 1'b0) begin $display("FAIL clear dropped_beat: got valid=%0b want 0", bus.out_valid); n_errors++; end
    n_checks++;
    drive(1'b1, 32'd3, 1'b1); tick();
    drive(1'b0, 32'd0, 1'b0);
    if (bus.out_sum !== 32'd3 || bus.out_beats !== 3'd1) begin
      $display("FAIL clear restart: got %0d/%0d want 3/1", bus.out_sum, bus.out_beats); n_errors++;
    end
    n_checks++;
    tick();
    // Clear leaves a held result untouched.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'd9, 1'b1); tick();
    drive(1'b0, 32'd0, 1'b0);
    bus.clear = 1'b1; tick();
    bus.clear = 1'b0;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 32'd9) begin
      $display("FAIL clear keeps_output: got %0b/%0d want 1/9", bus.out_valid, bus.out_sum); n_errors++;
    end
    n_checks++;
    bus.out_ready = 1'b1; tick();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'd20, 1'b0); tick();
    drive(1'b1, 32'd30, 1'b0); tick();
    drive(1'b0, 32'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    if (bus.out_sum !== 32'd0 || bus.out_beats !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_ovf !== 1'b0) begin
      $display("FAIL async_reset outputs: got %0d/%0d/%0b/%0b want 0/0/0/0",
               bus.out_sum, bus.out_beats, bus.out_valid, bus.out_ovf); n_errors++;
    end
    n_checks++;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'd8, 1'b1); tick();
    drive(1'b0, 32'd0, 1'b0);
    if (bus.out_sum !== 32'd8 || bus.out_beats !== 3'd1) begin
      $display("FAIL async_reset restart: got %0d/%0d want 8/1", bus.out_sum, bus.out_beats); n_errors++;
    end
    n_checks++;
    tick();
  endtask

  initial begin
    bus.clear     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_two_beats();
    test_single_beat();
    test_gap();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_saturation();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dot_accumulator.md
Name: dot_accumulator

Overview:
- Downstream consumer of the two-lane vector-dot pipeline.
- Takes the per-cycle partial dot product C (A1*B1 + A2*B2) and sums consecutive beats into the full-length dot product of a long vector.
- Presents the completed sum through a one-entry output register with a valid/ready handshake.
- Counts the beats in each vector and flags carry-out overflow.

Parameters:
- IN_W, 32: width of the partial-product input (matches pipeline C).
- ACC_W, 40: accumulator and result width; must be ≥ IN_W.
- CNT_W, 8: beat-counter width; a vector may hold at most 2^CNT_W − 1 beats.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort: discards the partial sum and returns to IDLE.
- in_valid  in  1  in_data holds a valid partial product this cycle.
- in_data  in  IN_W  partial dot product (unsigned) from the pipeline.
- in_last  in  1  marks the final beat of the current vector.
- in_ready  out  1  the block accepts a beat this cycle.
- out_valid  out  1  result register holds a completed sum.
- out_ready  in  1  the consumer takes the result this cycle.
- out_sum  out  ACC_W  completed vector dot product.
- out_beats  out  CNT_W  number of beats summed into out_sum.
- out_ovf  out  1  set if carry-out of ACC_W or beat-count saturation occurred in this vector.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; acc=0; cnt=0; ovf=0; out_valid=0; out_sum=0; out_beats=0; out_ovf=0.
- A beat is accepted when in_valid & in_ready.
- in_ready = ~out_valid | out_ready. This is combinational and stalls all input while an unread result is held.
- States:
  - IDLE: no partial sum held. An accepted non-last beat sets acc=in_data, cnt=1 → ACCUM. An accepted last beat goes straight to the output register (single-beat vector) and the state stays IDLE.
  - ACCUM: an accepted non-last beat sets acc+=in_data, cnt+=1. An accepted last beat loads the output register with acc+in_data and cnt+1, then clears acc, cnt and ovf → IDLE.
- Output load (same edge as the last beat is accepted):
  - out_sum = final sum mod 2^ACC_W; out_beats = final count; out_ovf = sticky ovf OR carry of the final add; out_valid=1.
- Latency: the result is visible one cycle after the last beat is accepted.
- Drain: when out_valid & out_ready with no new load, out_valid clears. When a load and a drain happen in the same cycle, the new result replaces the old one and out_valid stays 1. This gives full throughput back-to-back.
- Arithmetic:
  - in_data is zero-extended to ACC_W.
  - Any carry-out of bit ACC_W−1 sets sticky ovf; the sum wraps.
  - If cnt is already at 2^CNT_W−1, it saturates there and ovf is set.
- Holding: out_sum, out_beats and out_ovf stay stable while out_valid=1 and out_ready=0.
- in_valid=0: state and acc hold. Gaps between beats are allowed.
- clear=1:
  - Sets acc=0, cnt=0, ovf=0, state=IDLE, overriding any beat in the same cycle; that beat is dropped even if handshaken.
  - Does not touch the output register or out_valid.
- Reset mid-vector: the partial sum is lost and all outputs return to their reset values immediately.
- Ignored inputs:
  - in_data/in_last are don't-care when in_valid=0.
  - out_ready is ignored when out_valid=0.

Test Plan:
- Reset release, two beats C=6, C=6 (from A1=0,B1=1,A2=2,B2=3 then A1=3,B1=2,A2=1,B2=0) with in_last on the second, out_ready=1 → one cycle later out_valid=1, out_sum=12, out_beats=2, out_ovf=0; out_valid drops the next cycle.
- Single beat in_data=7, in_last=1 → out_sum=7, out_beats=1; state remains IDLE.
- Backpressure: complete vector {1,2} with out_ready=0, then offer {5} → in_ready=0 and out_sum holds 3. Raise out_ready → 3 drained; the next accepted beat yields out_sum=5.
- Overflow with ACC_W=IN_W=32: beats 0xFFFFFFFF, 0x00000002, last → out_sum=1, out_ovf=1. Following vector {4} → out_ovf=0.
- Mid-vector clear: beats 10, 20, then clear=1 together with in_valid=1 data 99, then {3, last} → out_sum=3, out_beats=1.
- Asynchronous reset asserted between clock edges during ACCUM with acc=50 → outputs zero immediately. After release, {8, last} → out_sum=8.
